// File: rtl/stack_lifo_param.sv
// rtl/stack_lifo_param.sv - parametrised LIFO stack with thermometer occupancy and sticky error flags
module stack_lifo_param #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic [DEPTH-1:0] occ,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    top_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             replace;
  logic             do_push;
  logic             do_pop;
  logic             ovf_set;
  logic             udf_set;

  assign top_ptr = AW'(cnt_q - 1'b1);
  assign wr_ptr  = AW'(cnt_q);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;

  // push+pop on an empty stack falls through to an ordinary push
  always_comb begin
    replace = push && pop && !empty;
    do_push = push && !replace && !full;
    do_pop  = pop && !push && !empty;
    ovf_set = push && !pop && full;
    udf_set = pop && !push && empty;
  end

  always_ff @(posedge clk) begin
    if (rst_n && (replace || do_push)) begin
      mem[replace ? top_ptr : wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
      overflow  <= ovf_set | (overflow & ~clr_err);
      underflow <= udf_set | (underflow & ~clr_err);
    end
  end

  assign dout = empty ? '0 : mem[top_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    assign occ[i] = (cnt_q > CW'(i));
  end

endmodule

// File: tb/tb_stack_lifo_param.sv
// tb/tb_stack_lifo_param.sv - vector table plus scoreboarded random ops for stack_lifo_param
module tb_stack_lifo_param;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] occ;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  always #5 clk = ~clk;

  stack_lifo_param #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .clr_err(clr_err),
    .dout(dout), .count(count), .occ(occ), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  typedef struct {
    logic             rst_n;
    logic             push;
    logic             pop;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dout;
    logic             ovf;
    logic             udf;
    string            name;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic r, input logic pu, input logic po, input logic c,
                              input logic [WIDTH-1:0] d, input int cn,
                              input logic [WIDTH-1:0] dq, input logic o, input logic u,
                              input string nm);
    vec_t v;
    v.rst_n = r; v.push = pu; v.pop = po; v.clr = c; v.din = d;
    v.cnt = CW'(cn); v.dout = dq; v.ovf = o; v.udf = u; v.name = nm;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    vec_t             e;
    logic [DEPTH-1:0] eocc;
    logic             eempty;
    logic             efull;
    @(negedge clk);
    rst_n = v.rst_n; push = v.push; pop = v.pop; clr_err = v.clr; din = v.din;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    for (int i = 0; i < DEPTH; i++) eocc[i] = (i < int'(e.cnt));
    eempty = (e.cnt == 0);
    efull  = (int'(e.cnt) == DEPTH);
    n_vec++;
    if (count !== e.cnt || occ !== eocc || empty !== eempty || full !== efull ||
        dout !== e.dout || overflow !== e.ovf || underflow !== e.udf) begin
      n_bad++;
      $display("FAIL %s: got count=%0d occ=%h empty=%b full=%b dout=%h ovf=%b udf=%b, want count=%0d occ=%h empty=%b full=%b dout=%h ovf=%b udf=%b",
               e.name, count, occ, empty, full, dout, overflow, underflow,
               e.cnt, eocc, eempty, efull, e.dout, e.ovf, e.udf);
    end
  endtask

  logic [WIDTH-1:0] mq[$];
  logic             mo;
  logic             mu;

  initial begin
    tbl.push_back(mk(0, 1, 0, 0, 32'hFFFF_FFFF, 0, 32'h0, 0, 0, "reset_with_push"));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 1, 0, 0, 32'h1100_0011 * k, k, 32'h1100_0011 * k, 0, 0, "fill"));
    tbl.push_back(mk(1, 1, 0, 0, 32'h9900_0099, 8, 32'h8800_0088, 1, 0, "overflow"));
    tbl.push_back(mk(1, 1, 1, 0, 32'hAA00_00AA, 8, 32'hAA00_00AA, 1, 0, "replace_full"));
    for (int k = 7; k >= 1; k--)
      tbl.push_back(mk(1, 0, 1, 0, 32'h0, k, 32'h1100_0011 * k, 1, 0, "drain"));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0, 0, 32'h0, 1, 0, "drain_last"));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0, 0, 32'h0, 1, 1, "underflow"));
    tbl.push_back(mk(1, 1, 1, 0, 32'h5A00_005A, 1, 32'h5A00_005A, 1, 1, "empty_push_pop"));
    tbl.push_back(mk(1, 0, 0, 0, 32'h1234_5678, 1, 32'h5A00_005A, 1, 1, "idle"));
    tbl.push_back(mk(1, 0, 1, 0, 32'h0, 0, 32'h0, 1, 1, "pop_to_empty"));
    tbl.push_back(mk(1, 0, 1, 1, 32'h0, 0, 32'h0, 0, 1, "clr_vs_new_underflow"));
    tbl.push_back(mk(1, 0, 0, 1, 32'h0, 0, 32'h0, 0, 0, "clr_alone"));
    foreach (tbl[i]) apply(tbl[i]);

    // overflow set wins over a simultaneous clear
    for (int k = 1; k <= 8; k++)
      apply(mk(1, 1, 0, 0, 32'hC000_0000 + k, k, 32'hC000_0000 + k, 0, 0, "refill"));
    apply(mk(1, 1, 0, 1, 32'h0BAD_0BAD, 8, 32'hC000_0008, 1, 0, "clr_vs_new_overflow"));
    apply(mk(1, 0, 1, 0, 32'h0, 7, 32'hC000_0007, 1, 0, "pop_after_overflow"));

    // reset mid-stream with push and pop both asserted
    apply(mk(0, 1, 1, 0, 32'h7777_7777, 0, 32'h0, 0, 0, "reset_mid_stream"));
    apply(mk(1, 1, 0, 0, 32'h0000_0003, 1, 32'h0000_0003, 0, 0, "push_after_reset"));
    apply(mk(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, "reset_again"));

    mq.delete(); mo = 1'b0; mu = 1'b0;
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      logic pu, po, c, os, us;
      logic [WIDTH-1:0] d;
      pu = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 7) == 0);
      d  = $urandom;
      os = 1'b0; us = 1'b0;
      if (pu && po && mq.size() > 0) mq[mq.size() - 1] = d;
      else if (pu) begin
        if (mq.size() < DEPTH) mq.push_back(d); else os = 1'b1;
      end else if (po) begin
        if (mq.size() > 0) void'(mq.pop_back()); else us = 1'b1;
      end
      mo = os | (mo & ~c);
      mu = us | (mu & ~c);
      v = mk(1, pu, po, c, d, mq.size(), (mq.size() > 0) ? mq[mq.size() - 1] : '0, mo, mu, "random");
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
